// File: rtl/pc_fetch_seq.sv
// rtl/pc_fetch_seq.sv - fetch program-counter sequencer with branch redirect and flush window
//
// Optional feature: define PC_ALIGN_CHECK_EN to reject taken branches whose
// target is not word aligned (misalign_out pulses instead of redirecting).
// Without it, unaligned targets are accepted and misalign_out is tied low.

module pc_fetch_seq #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          PC_STEP      = 4,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        br_valid_in,
    input  logic        br_taken_in,
    input  logic [31:0] br_target_in,
    output logic [31:0] PC_out,
    output logic [31:0] PC_next_out,
    output logic        fetch_valid_out,
    output logic        flush_out,
    output logic        br_ack_out,
    output logic [15:0] redirect_cnt_out,
    output logic        misalign_out
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Counter reload value: the counter counts the remaining flush cycles
    // minus one, so FLUSH exits on the edge after it reaches zero.
    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [31:0] STEP       = 32'(PC_STEP);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        ack_q, ack_d;
    logic [15:0] rc_q, rc_d;

    logic        br_take;
    logic        br_accept;
    logic        br_misalign;

    assign br_take = br_valid_in & br_taken_in;

`ifdef PC_ALIGN_CHECK_EN
    logic mis_q, mis_d;

    // A misaligned taken target is dropped entirely; only the flag records it.
    assign br_misalign = br_take & (br_target_in[1:0] != 2'b00);
    assign br_accept   = br_take & ~br_misalign;
    assign mis_d       = br_misalign;
    assign misalign_out = mis_q;

    // Misalign pulse register, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end
`else
    assign br_misalign  = 1'b0;
    assign br_accept    = br_take;
    assign misalign_out = 1'b0;
`endif

    // Next-state and next-PC selection; a redirect overrides stall and flush.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;
        ack_d   = 1'b0;
        rc_d    = rc_q;
        if (br_accept) begin
            pc_d    = br_target_in;
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
            flush_d = 1'b1;
            ack_d   = 1'b1;
            rc_d    = (rc_q == 16'hFFFF) ? rc_q : rc_q + 16'd1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!stall_in) begin
                        pc_d = pc_q + STEP;
                    end
                end
                ST_FLUSH: begin
                    // Flush window runs regardless of stall; PC holds at target.
                    if (cnt_q == 4'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State, PC, flush counter, pulses and redirect count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= 4'd0;
            flush_q <= 1'b0;
            ack_q   <= 1'b0;
            rc_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            ack_q   <= ack_d;
            rc_q    <= rc_d;
        end
    end

    assign PC_out           = pc_q;
    assign PC_next_out      = pc_q + STEP;
    assign fetch_valid_out  = (state_q == ST_RUN) & ~stall_in;
    assign flush_out        = flush_q;
    assign br_ack_out       = ack_q;
    assign redirect_cnt_out = rc_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb/tb_pc_fetch_seq.sv - self-checking bench for pc_fetch_seq (flush windows of 1 and 3)

module tb_pc_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        stall_in;
    logic        br_valid_in;
    logic        br_taken_in;
    logic [31:0] br_target_in;

    logic [31:0] pc_o   [2];
    logic [31:0] pcn_o  [2];
    logic        fv_o   [2];
    logic        fl_o   [2];
    logic        ack_o  [2];
    logic [15:0] rc_o   [2];
    logic        mis_o  [2];

    int n_pass;
    int n_total;

    // Reference state: PC, invalid fetch cycles still to come, pulses, count.
    int          fc     [2];
    logic [31:0] m_pc   [2];
    int          m_left [2];
    logic        m_fl   [2];
    logic        m_ack  [2];
    logic        m_mis  [2];
    int          m_rc   [2];

    pc_fetch_seq #(.RESET_PC(32'h0), .PC_STEP(4), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .br_valid_in(br_valid_in),
        .br_taken_in(br_taken_in), .br_target_in(br_target_in),
        .PC_out(pc_o[0]), .PC_next_out(pcn_o[0]), .fetch_valid_out(fv_o[0]),
        .flush_out(fl_o[0]), .br_ack_out(ack_o[0]), .redirect_cnt_out(rc_o[0]),
        .misalign_out(mis_o[0]));

    pc_fetch_seq #(.RESET_PC(32'h0), .PC_STEP(4), .FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .br_valid_in(br_valid_in),
        .br_taken_in(br_taken_in), .br_target_in(br_target_in),
        .PC_out(pc_o[1]), .PC_next_out(pcn_o[1]), .fetch_valid_out(fv_o[1]),
        .flush_out(fl_o[1]), .br_ack_out(ack_o[1]), .redirect_cnt_out(rc_o[1]),
        .misalign_out(mis_o[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: advance one clock edge, or clear on reset.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_pc[i] = 32'h0; m_left[i] = 0; m_fl[i] = 1'b0;
                m_ack[i] = 1'b0; m_mis[i] = 1'b0; m_rc[i] = 0;
            end else begin
                logic take, bad, acc;
                take = br_valid_in && br_taken_in;
`ifdef PC_ALIGN_CHECK_EN
                bad = take && (br_target_in % 4 != 0);
`else
                bad = 1'b0;
`endif
                acc = take && !bad;
                m_fl[i] = acc; m_ack[i] = acc; m_mis[i] = bad;
                if (acc) begin
                    m_pc[i] = br_target_in;
                    m_left[i] = fc[i];
                    if (m_rc[i] < 65535) m_rc[i] = m_rc[i] + 1;
                end else if (m_left[i] > 0) begin
                    m_left[i] = m_left[i] - 1;
                end else if (!stall_in) begin
                    m_pc[i] = m_pc[i] + 32'd4;
                end
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pc[%0d]", i), pc_o[i], m_pc[i]);
            chk($sformatf("pc_next[%0d]", i), pcn_o[i], m_pc[i] + 32'd4);
            chk($sformatf("fetch_valid[%0d]", i), 32'(fv_o[i]), 32'(m_left[i] == 0 && !stall_in));
            chk($sformatf("flush[%0d]", i), 32'(fl_o[i]), 32'(m_fl[i]));
            chk($sformatf("ack[%0d]", i), 32'(ack_o[i]), 32'(m_ack[i]));
            chk($sformatf("rc[%0d]", i), 32'(rc_o[i]), 32'(m_rc[i]));
            chk($sformatf("misalign[%0d]", i), 32'(mis_o[i]), 32'(m_mis[i]));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic t, input logic [31:0] tg);
        stall_in = s; br_valid_in = v; br_taken_in = t; br_target_in = tg;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        fc[0] = 1; fc[1] = 3;
        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0);
        #13;
        rst_n = 1'b1;
        #1;
        chk("reset_pc", pc_o[0], 32'h0);
        chk("reset_valid", 32'(fv_o[0]), 32'd1);
        chk("reset_rc", 32'(rc_o[1]), 32'd0);

        // Sequential fetch from reset.
        tick(); chk("seq_pc4", pc_o[0], 32'h4);
        tick(); chk("seq_pc8", pc_o[0], 32'h8);
        tick(); chk("seq_pcC", pc_o[0], 32'hC);

        // Taken branch to 0x100.
        drive(0, 1, 1, 32'h100);
        tick(); drive(0, 0, 0, 32'h0);
        chk("br_pc", pc_o[0], 32'h100);
        chk("br_flush", 32'(fl_o[0]), 32'd1);
        chk("br_ack", 32'(ack_o[0]), 32'd1);
        chk("br_valid0", 32'(fv_o[0]), 32'd0);
        chk("br_rc", 32'(rc_o[0]), 32'd1);
        tick();
        chk("br_valid1", 32'(fv_o[0]), 32'd1);
        chk("br_pc_hold", pc_o[0], 32'h100);
        chk("br_flush_clr", 32'(fl_o[0]), 32'd0);
        tick(); tick(); tick();

        // Not-taken branch is ignored.
        drive(0, 1, 0, 32'h800);
        tick(); drive(0, 0, 0, 32'h0);
        chk("nt_rc", 32'(rc_o[0]), 32'd1);

        // Branch and stall in the same cycle.
        drive(1, 1, 1, 32'h40);
        tick(); drive(1, 0, 0, 32'h0);
        chk("stallbr_pc", pc_o[0], 32'h40);
        chk("stallbr_flush", 32'(fl_o[0]), 32'd1);
        tick(); tick(); tick(); drive(0, 0, 0, 32'h0); tick();

        // Redirect in the second flush cycle of the 3-cycle instance.
        drive(0, 1, 1, 32'h300);
        tick(); drive(0, 0, 0, 32'h0);
        tick(); drive(0, 1, 1, 32'h200);
        tick(); drive(0, 0, 0, 32'h0);
        chk("reflush_pc", pc_o[1], 32'h200);
        chk("reflush_rc", 32'(rc_o[1]), 32'd4);
        chk("reflush_v0", 32'(fv_o[1]), 32'd0);
        tick(); chk("reflush_v1", 32'(fv_o[1]), 32'd0);
        tick(); chk("reflush_v2", 32'(fv_o[1]), 32'd0);
        tick(); chk("reflush_v3", 32'(fv_o[1]), 32'd1);
        chk("reflush_pc_hold", pc_o[1], 32'h200);

        // Wrap at the top of the address space.
        drive(0, 1, 1, 32'hFFFF_FFFC);
        tick(); drive(0, 0, 0, 32'h0);
        tick();
        chk("wrap_next", pcn_o[0], 32'h0);
        tick();
        chk("wrap_pc", pc_o[0], 32'h0);
        chk("wrap_flush", 32'(fl_o[0]), 32'd0);
        tick(); tick(); tick();

`ifdef PC_ALIGN_CHECK_EN
        // Misaligned target is rejected; PC keeps stepping.
        drive(0, 1, 1, 32'h0000_0010);
        tick(); drive(0, 0, 0, 32'h0);
        tick(); tick(); tick(); tick();
        begin
            logic [31:0] p0;
            p0 = pc_o[0];
            drive(0, 1, 1, 32'h102);
            tick(); drive(0, 0, 0, 32'h0);
            chk("mis_pc", pc_o[0], p0 + 32'd4);
            chk("mis_flag", 32'(mis_o[0]), 32'd1);
            chk("mis_flush", 32'(fl_o[0]), 32'd0);
        end
`endif

        // Reset asserted in the middle of a flush window.
        drive(0, 1, 1, 32'h500);
        tick(); drive(0, 0, 0, 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstflush_pc", pc_o[1], 32'h0);
        chk("rstflush_flush", 32'(fl_o[1]), 32'd0);
        chk("rstflush_ack", 32'(ack_o[1]), 32'd0);
        chk("rstflush_rc", 32'(rc_o[1]), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic s, v, t;
            logic [31:0] tg;
            s = ($urandom_range(0, 9) < 3);
            v = ($urandom_range(0, 3) == 0);
            t = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 7))
                0: tg = $urandom;
                1: tg = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
                default: tg = $urandom & 32'hFFFF_FFFC;
            endcase
            drive(s, v, t, tg);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
